// File: rtl/hs_elastic_fifo_pkg.sv
// Shared handshake constants and helpers for the elastic req/ack FIFO.
package hs_elastic_fifo_pkg;

  localparam int ACK_PULSE_CYCLES = 1;
  localparam int MIN_FIFO_DEPTH   = 2;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/hs_fifo_mem.sv
// Storage array for the elastic FIFO: one synchronous write port, one
// combinational read port sampled by the owner at pop time.
module hs_fifo_mem #(
  parameter int data_width = 32,
  parameter int depth      = 4,
  parameter int addr_width = 2
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [addr_width-1:0] waddr_i,
  input  logic [data_width-1:0] wdata_i,
  input  logic [addr_width-1:0] raddr_i,
  output logic [data_width-1:0] rdata_o
);

  logic [data_width-1:0] mem_q [depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // A same-edge write to the read slot only happens when full, so the old word is the one wanted.
  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/hs_elastic_fifo.sv
// Elastic buffer between an upstream responder (up_req/up_ack) and a
// downstream requester (dn_req/dn_ack), with occupancy and transfer counters.
module hs_elastic_fifo
  import hs_elastic_fifo_pkg::*;
#(
  parameter  int data_width = 32,
  parameter  int depth      = 4,
  localparam int addr_width = clog2((depth > MIN_FIFO_DEPTH) ? depth : MIN_FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  up_req,
  input  logic                  up_ack,
  input  logic [data_width-1:0] up_din,
  input  logic                  dn_req,
  output logic                  dn_ack,
  output logic [data_width-1:0] dn_dout,
  output logic [addr_width:0]   level,
  output logic [31:0]           count_in,
  output logic [31:0]           count_out,
  output logic                  err
);

  localparam logic [addr_width:0] LVL_FULL    = (addr_width + 1)'(depth);
  // Keep one slot spare per ack that may already be in flight when req drops.
  localparam logic [addr_width:0] LVL_REQ_MAX = (addr_width + 1)'(depth - ACK_PULSE_CYCLES - 1);

  logic [addr_width-1:0] wr_ptr_q, wr_ptr_d;
  logic [addr_width-1:0] rd_ptr_q, rd_ptr_d;
  logic [addr_width:0]   level_q, level_d;
  logic [31:0]           count_in_q, count_in_d;
  logic [31:0]           count_out_q, count_out_d;
  logic                  up_req_q, up_req_d;
  logic                  dn_ack_q, dn_ack_d;
  logic                  err_q, err_d;
  logic [data_width-1:0] dn_dout_q, dn_dout_d;
  logic [data_width-1:0] mem_rdata;
  logic                  wr_en;
  logic                  rd_en;

  hs_fifo_mem #(
    .data_width (data_width),
    .depth      (depth),
    .addr_width (addr_width)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q),
    .wdata_i (up_din),
    .raddr_i (rd_ptr_q),
    .rdata_o (mem_rdata)
  );

  always_comb begin
    rd_en       = dn_req && !dn_ack_q && (level_q != '0);
    // A pop on the same edge frees a slot, so a full buffer still accepts.
    wr_en       = up_ack && ((level_q != LVL_FULL) || rd_en);

    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_in_d  = count_in_q;
    count_out_d = count_out_q;
    dn_dout_d   = dn_dout_q;
    dn_ack_d    = rd_en;
    err_d       = err_q | (up_ack & ~wr_en);

    if (wr_en) begin
      wr_ptr_d   = wr_ptr_q + addr_width'(1);
      count_in_d = count_in_q + 32'd1;
    end
    if (rd_en) begin
      rd_ptr_d    = rd_ptr_q + addr_width'(1);
      count_out_d = count_out_q + 32'd1;
      dn_dout_d   = mem_rdata;
    end

    level_d  = level_q + {{addr_width{1'b0}}, wr_en} - {{addr_width{1'b0}}, rd_en};
    up_req_d = (level_d <= LVL_REQ_MAX);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      count_in_q  <= '0;
      count_out_q <= '0;
      up_req_q    <= 1'b0;
      dn_ack_q    <= 1'b0;
      err_q       <= 1'b0;
      dn_dout_q   <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      count_in_q  <= count_in_d;
      count_out_q <= count_out_d;
      up_req_q    <= up_req_d;
      dn_ack_q    <= dn_ack_d;
      err_q       <= err_d;
      dn_dout_q   <= dn_dout_d;
    end
  end

  assign up_req    = up_req_q;
  assign dn_ack    = dn_ack_q;
  assign dn_dout   = dn_dout_q;
  assign level     = level_q;
  assign count_in  = count_in_q;
  assign count_out = count_out_q;
  assign err       = err_q;

endmodule

// File: tb/tb_hs_elastic_fifo.sv
// Directed bench for hs_elastic_fifo (depth 4, 32-bit words).
module tb_hs_elastic_fifo;

  logic        clk;
  logic        rst;
  logic        up_req;
  logic        up_ack;
  logic [31:0] up_din;
  logic        dn_req;
  logic        dn_ack;
  logic [31:0] dn_dout;
  logic [2:0]  level;
  logic [31:0] count_in;
  logic [31:0] count_out;
  logic        err;

  int          checks;
  int          errors;
  logic [31:0] next_val;
  logic [31:0] exp_rd;
  logic        prev_ack;
  logic        prod_en;
  logic        cons_en;
  logic        chk_req;
  int          n;
  logic [31:0] ci, co, c0;

  hs_elastic_fifo dut (
    .clk       (clk),
    .rst       (rst),
    .up_req    (up_req),
    .up_ack    (up_ack),
    .up_din    (up_din),
    .dn_req    (dn_req),
    .dn_ack    (dn_ack),
    .dn_dout   (dn_dout),
    .level     (level),
    .count_in  (count_in),
    .count_out (count_out),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  // One clock: check any delivered word, then let the bench producer/consumer react.
  task automatic step();
    @(posedge clk);
    #1;
    if (dn_ack) begin
      chk("dn_ack_gap", {31'd0, prev_ack}, 32'd0);
      chk("dn_dout", dn_dout, exp_rd);
      exp_rd = exp_rd + 1;
    end
    prev_ack = dn_ack;
    if (chk_req) chk("up_req_thr", {31'd0, up_req}, {31'd0, (level <= 3'd2)});
    if (prod_en) begin
      if (up_req && !up_ack) begin
        up_ack   = 1'b1;
        up_din   = next_val;
        next_val = next_val + 1;
      end else begin
        up_ack = 1'b0;
      end
    end
    if (cons_en) dn_req = 1'b1;
  endtask

  task automatic push_one();
    up_ack   = 1'b1;
    up_din   = next_val;
    next_val = next_val + 1;
    step();
    up_ack = 1'b0;
    step();
  endtask

  initial begin
    checks = 0; errors = 0;
    next_val = 0; exp_rd = 0; prev_ack = 0;
    prod_en = 0; cons_en = 0; chk_req = 0;
    rst = 1; up_ack = 0; up_din = 0; dn_req = 0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_up_req", {31'd0, up_req}, 32'd0);
    chk("rst_dn_ack", {31'd0, dn_ack}, 32'd0);
    chk("rst_level", {29'd0, level}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    rst = 0;
    chk("rel_up_req", {31'd0, up_req}, 32'd0);
    step();
    chk("idle_up_req", {31'd0, up_req}, 32'd1);
    chk_req = 1;

    // Empty buffer ignores downstream requests.
    cons_en = 1;
    repeat (5) step();
    chk("empty_count_out", count_out, 32'd0);
    chk("empty_dn_ack", {31'd0, dn_ack}, 32'd0);
    chk("empty_err", {31'd0, err}, 32'd0);
    cons_en = 0; dn_req = 0;

    // Fill with a compliant producer and no consumer: settles at 3.
    prod_en = 1;
    repeat (20) step();
    chk("fill_level", {29'd0, level}, 32'd3);
    chk("fill_up_req", {31'd0, up_req}, 32'd0);
    chk("fill_err", {31'd0, err}, 32'd0);
    chk("fill_count_in", count_in, 32'd3);
    prod_en = 0;
    step();
    up_ack = 0;

    // One extra (in-flight style) ack fills it, the next one overflows.
    up_ack = 1; up_din = next_val; next_val = next_val + 1;
    step();
    chk("full_level", {29'd0, level}, 32'd4);
    up_ack = 1; up_din = 32'hDEAD;
    step();
    up_ack = 0;
    chk("ovf_err", {31'd0, err}, 32'd1);
    chk("ovf_level", {29'd0, level}, 32'd4);
    chk("ovf_count_in", count_in, 32'd4);
    repeat (3) step();
    chk("ovf_err_sticky", {31'd0, err}, 32'd1);

    // Drain: expect 0,1,2,3 in order, never 0xDEAD.
    cons_en = 1;
    n = 0;
    while (count_out < 4 && n < 50) begin step(); n++; end
    chk("drain_timeout", {31'd0, (n < 50)}, 32'd1);
    step();
    chk("drain_level", {29'd0, level}, 32'd0);
    chk("drain_last", dn_dout, 32'd3);
    cons_en = 0; dn_req = 0;
    step();

    // Same-edge write and read at level 2.
    push_one();
    push_one();
    chk("pre_same_level", {29'd0, level}, 32'd2);
    ci = count_in; co = count_out;
    up_ack = 1; up_din = next_val; next_val = next_val + 1;
    dn_req = 1;
    step();
    up_ack = 0; dn_req = 0;
    chk("same_level", {29'd0, level}, 32'd2);
    chk("same_count_in", count_in, ci + 1);
    chk("same_count_out", count_out, co + 1);
    chk("same_dout", dn_dout, 32'd4);
    chk("same_dn_ack", {31'd0, dn_ack}, 32'd1);

    // Continuous streaming.
    prod_en = 1; cons_en = 1;
    n = 0;
    while (count_out < 1000 && n < 5000) begin step(); n++; end
    chk("stream_timeout", {31'd0, (n < 5000)}, 32'd1);
    c0 = count_out;
    repeat (1000) step();
    chk("stream_rate", {31'd0, ((count_out - c0) >= 499) && ((count_out - c0) <= 501)}, 32'd1);
    chk("stream_occ", {31'd0, ((count_in - count_out) <= 4)}, 32'd1);
    chk("stream_level", {29'd0, level}, count_in - count_out);
    chk("stream_err", {31'd0, err}, 32'd1);

    // Stop, drain, then set up level 3 with dn_ack high and reset asynchronously.
    prod_en = 0;
    step();
    up_ack = 0;
    n = 0;
    while (level != 0 && n < 50) begin step(); n++; end
    chk("rdrain_timeout", {31'd0, (n < 50)}, 32'd1);
    cons_en = 0; dn_req = 0;
    step();
    repeat (4) push_one();
    chk("pre_rst_level", {29'd0, level}, 32'd4);
    dn_req = 1;
    step();
    dn_req = 0;
    chk("pre_rst_level3", {29'd0, level}, 32'd3);
    chk("pre_rst_ack", {31'd0, dn_ack}, 32'd1);
    #2;
    rst = 1;
    chk_req = 0;
    #1;
    chk("arst_up_req", {31'd0, up_req}, 32'd0);
    chk("arst_dn_ack", {31'd0, dn_ack}, 32'd0);
    chk("arst_dn_dout", dn_dout, 32'd0);
    chk("arst_level", {29'd0, level}, 32'd0);
    chk("arst_count_in", count_in, 32'd0);
    chk("arst_count_out", count_out, 32'd0);
    chk("arst_err", {31'd0, err}, 32'd0);
    next_val = 32'd100; exp_rd = 32'd100; prev_ack = 0;
    @(posedge clk);
    #1;
    rst = 0;
    step();
    chk("post_rst_up_req", {31'd0, up_req}, 32'd1);
    chk_req = 1;
    prod_en = 1; cons_en = 1;
    n = 0;
    while (count_out < 3 && n < 50) begin step(); n++; end
    chk("post_rst_timeout", {31'd0, (n < 50)}, 32'd1);
    chk("post_rst_exp", exp_rd, 32'd103);
    chk("post_rst_err", {31'd0, err}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hs_elastic_fifo.md
Name: hs_elastic_fifo

Overview:
- Elastic req/ack buffer that decouples a data source (producer or `in` operator) from the downstream async_operator input port it feeds.
- Upstream side acts as a requester and pulls words with up_req/up_ack. Downstream side acts as a responder and delivers words with a one-cycle dn_ack pulse.
- Absorbs producer/consumer stalls (fail_rate > 0) without losing data, and exposes occupancy and transfer counters for throughput benches.

Parameters:
- data_width, 32, word width.
- depth, 4, number of storage slots; power of two, minimum 2.
- addr_width, log2(depth), pointer width; derived, not overridden.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  asynchronous active-high reset.
- up_req  output  1  request to upstream responder.
- up_ack  input  1  one-cycle pulse from upstream; up_din is valid while high.
- up_din  input  data_width  upstream data.
- dn_req  input  1  request from downstream requester.
- dn_ack  output  1  one-cycle pulse; dn_dout is valid.
- dn_dout  output  data_width  downstream data.
- level  output  addr_width+1  current occupancy, 0..depth.
- count_in  output  32  words accepted since reset.
- count_out  output  32  words delivered since reset.
- err  output  1  sticky overflow flag.

Behaviour:
- Reset (async, rst=1): up_req=0, dn_ack=0, dn_dout=0, level=0, wr_ptr=rd_ptr=0, count_in=count_out=0, err=0. Memory contents are don't-care.
- A reset mid-transfer discards all stored words and any in-flight ack.
- Write event: up_ack=1 sampled at an edge and level<depth.
  - mem[wr_ptr]<=up_din; wr_ptr increments mod depth; count_in increments.
- Overflow: up_ack=1 while level==depth.
  - Word is dropped; err<=1 and stays set until reset.
  - Pointers, level and count_in are unchanged.
- Read event: at an edge where dn_req=1, dn_ack=0 and level>0.
  - dn_ack<=1 and dn_dout<=mem[rd_ptr]; rd_ptr increments mod depth; count_out increments.
- Otherwise dn_ack<=0.
- dn_dout holds its value until the next read event. Data must be stable no later than the dn_ack rising edge, because the downstream captures on posedge ack.
- Read uses level before the edge, so a word written at edge E is deliverable at edge E+1 at the earliest. Latency is 1 cycle, with no fall-through.
- Simultaneous write and read: both occur; level is unchanged. A read at level==depth with a simultaneous up_ack is not an overflow. Overflow is judged on level before the edge plus the read, i.e. write succeeds if level - rd < depth.
- level_next = level + wr - rd, where wr and rd are 1-bit events.
- up_req<=(level_next <= depth-2), evaluated every edge.
  - Requiring two free slots covers the one upstream ack that may still be in flight.
  - With a rule-compliant upstream (acks only on req & ~ack), overflow is impossible.
  - up_req is not dropped on ack. Continuous req gives 1 word per 2 cycles, matching the upstream ack rate.
- Downstream throughput is at most 1 word per 2 cycles (dn_ack is never high on consecutive cycles).
- Pointer wrap: depth is a power of two, so natural overflow of the addr_width bits is used.
- level reaches depth only through in-flight acks. It is never exceeded.
- up_din is ignored when up_ack=0. dn_req is ignored when empty; no dn_ack is issued.

Decomposition:
- Shared package holds the handshake constants: ACK_PULSE_CYCLES=1 and MIN_FIFO_DEPTH=2, plus a clog2 function used for addr_width.
- One natural sub-module: hs_fifo_mem, a depth x data_width register array with one synchronous write port and one read-at-pop port.
- Pointer, level, counter and handshake logic stay in hs_elastic_fifo.

Test Plan:
- Reset then idle, no up_ack → up_req rises 1 cycle after reset release; level=0; dn_req=1 yields no dn_ack; err=0.
- Producer (fail_rate 0, values 0,1,2...) feeding the FIFO; consumer always requesting → consumer receives 0,1,2,... in order. After 5000 words count_in-count_out ≤ depth and the steady-state rate is 1 word per 2 cycles.
- depth=4, dn_req held 0, producer supplying → level climbs to 3 or 4 and stops; up_req=0 once level≥3; err stays 0. Then dn_req=1 → words 0,1,2,3 delivered, and up_req re-asserts when level ≤ 2.
- Forced up_ack pulse while level==4, up_din=0xDEAD → err=1 sticky; level stays 4; 0xDEAD is never output; count_in unchanged.
- Same-edge write and read at level=2 → level stays 2; count_in and count_out both +1; dn_dout equals the oldest word.
- Assert rst while level=3 and dn_ack=1 → all outputs return to reset values immediately (asynchronous). After release, the first delivered word is the first word accepted post-reset.
